// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 control-port responder: device address,
// register map, power-on register values and the packet-decoder state encoding.
package wm8731_pkg;

  localparam logic [6:0]  DEV_ADDR_DEF = 7'h1A;
  localparam int unsigned NUM_REGS     = 10;
  localparam int unsigned REG_W        = 9;

  typedef enum logic [6:0] {
    R_LLIN   = 7'h00,
    R_RLIN   = 7'h01,
    R_LHP    = 7'h02,
    R_RHP    = 7'h03,
    R_AAPC   = 7'h04,
    R_DAPC   = 7'h05,
    R_PDC    = 7'h06,
    R_DAIF   = 7'h07,
    R_SRC    = 7'h08,
    R_ACTIVE = 7'h09,
    R_RESET  = 7'h0F
  } wm_reg_e;

  // Element [0] is the rightmost entry, so the list runs R9 down to R0.
  localparam logic [NUM_REGS-1:0][REG_W-1:0] REG_DEFAULTS = {
    9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
    9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK0,
    ST_BYTE1,
    ST_ACK1,
    ST_BYTE2,
    ST_ACK2,
    ST_WAIT_STOP,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C line: synchronizer, optional stability filter, and
// registered level plus rise/fall pulses that are aligned with each other.
module i2c_line_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   cond;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], line_i};

  generate
    if (FILTER_LEN > 0) begin : g_filter
      localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

      logic             filt_q, filt_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Output follows the line only after FILTER_LEN consecutive disagreeing samples.
      always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
          if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            filt_d = sync_q[SYNC_STAGES-1];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          filt_q <= 1'b1;
          cnt_q  <= '0;
        end else begin
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign cond = filt_q;
    end else begin : g_direct
      assign cond = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    level_d = cond;
    rise_d  = cond & ~level_q;
    fall_d  = ~cond & level_q;
  end

  // Idle bus level is high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C target modelling the WM8731 control port: decodes 24-bit write packets into the
// codec register file. Define I2C_GLITCH_FILTER_EN to add a stability filter on SCL/SDA.
module i2c_codec_responder
  import wm8731_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  input  logic [3:0] reg_rd_addr,
  output logic [8:0] reg_rd_data,
  output logic       reg_wr_stb,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  output logic       busy,
  output logic       bad_reg,
  output logic       abort_err
);

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned FILT_EFF = FILTER_LEN;
`else
  // A zero length selects the bare synchronizer path in the line conditioners.
  localparam int unsigned FILT_EFF = FILTER_LEN * 0;
`endif

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILT_EFF)) u_scl_cond (
    .clk    (clk),
    .reset  (reset),
    .line_i (i2c_sclk),
    .level  (scl_lvl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILT_EFF)) u_sda_cond (
    .clk    (clk),
    .reset  (reset),
    .line_i (i2c_sdat),
    .level  (sda_lvl),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e                       state_q, state_d;
  logic [2:0]                       bit_cnt_q, bit_cnt_d;
  logic [7:0]                       shift_q, shift_d;
  logic [7:0]                       byte1_q, byte1_d;
  logic                             sda_oe_q, sda_oe_d;
  logic                             busy_q, busy_d;
  logic                             wr_stb_q, wr_stb_d;
  logic                             bad_reg_q, bad_reg_d;
  logic                             abort_q, abort_d;
  logic [6:0]                       wr_addr_q, wr_addr_d;
  logic [8:0]                       wr_data_q, wr_data_d;
  logic [8:0]                       rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0][REG_W-1:0]   regs_q, regs_d;

  logic [7:0] shift_in;
  logic [6:0] reg_idx;
  logic [8:0] wr_word;

  assign shift_in = {shift_q[6:0], sda_lvl};
  assign reg_idx  = byte1_q[7:1];
  assign wr_word  = {byte1_q[0], shift_in};

  // Packet decoder; START/STOP override every state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte1_d   = byte1_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    bad_reg_d = 1'b0;
    abort_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d    = regs_q;

    if (start_det || stop_det) begin
      sda_oe_d = 1'b0;
      if (state_q inside {ST_ACK0, ST_BYTE1, ST_ACK1, ST_BYTE2}) begin
        abort_d = 1'b1;
      end
      if (start_det) begin
        state_d   = ST_ADDR;
        bit_cnt_d = '0;
        busy_d    = 1'b1;
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = (shift_in[7:1] == DEV_ADDR && !shift_in[0]) ? ST_ACK0 : ST_IGNORE;
            end
          end
        end
        ST_BYTE1: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte1_d = shift_in;
              state_d = ST_ACK1;
            end
          end
        end
        ST_BYTE2: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_addr_d = reg_idx;
              wr_data_d = wr_word;
              state_d   = ST_ACK2;
              if (reg_idx <= 7'(R_ACTIVE)) begin
                regs_d[reg_idx[3:0]] = wr_word;
                wr_stb_d             = 1'b1;
              end else if (reg_idx == 7'(R_RESET)) begin
                regs_d   = REG_DEFAULTS;
                wr_stb_d = 1'b1;
              end else begin
                bad_reg_d = 1'b1;
              end
            end
          end
        end
        // First SCL fall starts driving the ACK, the second one ends the ACK slot.
        ST_ACK0, ST_ACK1, ST_ACK2: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              case (state_q)
                ST_ACK0: state_d = ST_BYTE1;
                ST_ACK1: state_d = ST_BYTE2;
                default: state_d = ST_WAIT_STOP;
              endcase
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read port sees registered state only, so a same-cycle write returns the old value.
  always_comb begin
    rd_data_d = '0;
    if ({3'b000, reg_rd_addr} <= 7'(R_ACTIVE)) begin
      rd_data_d = regs_q[reg_rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte1_q   <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      bad_reg_q <= 1'b0;
      abort_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      regs_q    <= REG_DEFAULTS;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte1_q   <= byte1_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      bad_reg_q <= bad_reg_d;
      abort_q   <= abort_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      regs_q    <= regs_d;
    end
  end

  assign i2c_sdat    = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_rd_data = rd_data_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign bad_reg     = bad_reg_q;
  assign abort_err   = abort_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master, table of write packets,
// event scoreboard and a reference register-file model.
module tb_i2c_codec_responder;

  localparam int unsigned Q = 6;
  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_WR    = 3'b100;
  localparam logic [2:0] K_BAD   = 3'b010;
  localparam logic [2:0] K_ABORT = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [6:0] addr;
    logic [8:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [2:0] acks;
    logic [2:0] kind;
    logic [6:0] ra;
    logic [8:0] rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl;
  logic       m_sda_low;
  logic [3:0] reg_rd_addr;
  logic [8:0] reg_rd_data;
  logic       reg_wr_stb;
  logic [6:0] reg_wr_addr;
  logic [8:0] reg_wr_data;
  logic       busy;
  logic       bad_reg;
  logic       abort_err;
  wire        sdat;

  pullup (sdat);
  assign sdat = m_sda_low ? 1'b0 : 1'bz;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [8:0] mregs [10];
  vec_t vt [8];

  always #5 clk = ~clk;

  i2c_codec_responder dut (
    .clk         (clk),
    .reset       (reset),
    .i2c_sclk    (m_scl),
    .i2c_sdat    (sdat),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .busy        (busy),
    .bad_reg     (bad_reg),
    .abort_err   (abort_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_defaults();
    mregs[0] = 9'h097; mregs[1] = 9'h097; mregs[2] = 9'h079; mregs[3] = 9'h079;
    mregs[4] = 9'h00A; mregs[5] = 9'h008; mregs[6] = 9'h09F; mregs[7] = 9'h00A;
    mregs[8] = 9'h000; mregs[9] = 9'h000;
  endtask

  task automatic model_apply(input logic [2:0] kind, input logic [6:0] ra, input logic [8:0] d);
    if (kind == K_WR) begin
      if (ra <= 7'd9) mregs[ra[3:0]] = d;
      else if (ra == 7'h0F) model_defaults();
    end
  endtask

  task automatic expect_evt(input logic [2:0] kind, input logic [6:0] ra, input logic [8:0] d);
    exp_t e;
    e.kind = kind;
    e.addr = ra;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 10; i++) begin
      reg_rd_addr = 4'(i);
      wait_clk(1);
      chk($sformatf("%s_rd_R%0d", tag, i), 32'(reg_rd_data), 32'(mregs[i]));
    end
  endtask

  task automatic do_start();
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(2 * Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic do_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(2 * Q);
    m_sda_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(2 * Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_bit_glitch(input logic b);
    m_sda_low = ~b;
    wait_clk(2);
    m_scl = 1'b1;
    wait_clk(2);
    m_scl = 1'b0;
    wait_clk(Q - 4);
    m_scl = 1'b1;
    wait_clk(2 * Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic get_ack(output logic ack);
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    ack = (sdat == 1'b0);
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic ack;
    if (v.kind != K_NONE) expect_evt(v.kind, v.ra, v.rd);
    do_start();
    send_byte(v.a);
    get_ack(ack);
    chk($sformatf("v%0d_ack_addr", idx), 32'(ack), 32'(v.acks[2]));
    send_byte(v.b1);
    get_ack(ack);
    chk($sformatf("v%0d_ack_b1", idx), 32'(ack), 32'(v.acks[1]));
    send_byte(v.b2);
    get_ack(ack);
    chk($sformatf("v%0d_ack_b2", idx), 32'(ack), 32'(v.acks[0]));
    chk($sformatf("v%0d_busy_pre_stop", idx), 32'(busy), 32'd1);
    do_stop();
    chk($sformatf("v%0d_busy_post_stop", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_sb_drained", idx), 32'(sbq.size()), 32'd0);
    model_apply(v.kind, v.ra, v.rd);
    readback($sformatf("v%0d", idx));
  endtask

  // Scoreboard consumer: every DUT pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && (reg_wr_stb || bad_reg || abort_err)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: stb=%0b bad=%0b abort=%0b, expected no event",
                 reg_wr_stb, bad_reg, abort_err);
      end else begin
        mon_e = sbq.pop_front();
        chk("evt_kind", 32'({reg_wr_stb, bad_reg, abort_err}), 32'(mon_e.kind));
        if (mon_e.kind != K_ABORT) begin
          chk("evt_wr_addr", 32'(reg_wr_addr), 32'(mon_e.addr));
          chk("evt_wr_data", 32'(reg_wr_data), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    vt[0] = '{8'h34, 8'h08, 8'h12, 3'b111, K_WR,   7'h04, 9'h012};
    vt[1] = '{8'h36, 8'h08, 8'h12, 3'b000, K_NONE, 7'h00, 9'h000};
    vt[2] = '{8'h34, 8'h03, 8'hFF, 3'b111, K_WR,   7'h01, 9'h1FF};
    vt[3] = '{8'h34, 8'h1E, 8'h00, 3'b111, K_WR,   7'h0F, 9'h000};
    vt[4] = '{8'h34, 8'h14, 8'h55, 3'b111, K_BAD,  7'h0A, 9'h055};
    vt[5] = '{8'h34, 8'h0E, 8'h01, 3'b111, K_WR,   7'h07, 9'h001};
    vt[6] = '{8'h35, 8'h0E, 8'h01, 3'b000, K_NONE, 7'h00, 9'h000};
    vt[7] = '{8'h34, 8'h13, 8'h80, 3'b111, K_WR,   7'h09, 9'h180};

    reset       = 1'b1;
    m_scl       = 1'b1;
    m_sda_low   = 1'b0;
    reg_rd_addr = 4'd0;
    model_defaults();
    wait_clk(3);
    chk("rst_sdat_released", 32'(sdat), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stb", 32'(reg_wr_stb), 32'd0);
    chk("rst_bad", 32'(bad_reg), 32'd0);
    chk("rst_abort", 32'(abort_err), 32'd0);
    chk("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
    chk("rst_rd_data", 32'(reg_rd_data), 32'd0);
    reset = 1'b0;
    wait_clk(5);
    readback("post_rst");

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

    // Extra byte after a complete packet must be NACKed.
    expect_evt(K_WR, 7'h05, 9'h05A);
    do_start();
    send_byte(8'h34); get_ack(ack);
    send_byte(8'h0A); get_ack(ack);
    send_byte(8'h5A); get_ack(ack);
    chk("extra_ack_b2", 32'(ack), 32'd1);
    send_byte(8'hAA); get_ack(ack);
    chk("extra_byte_nack", 32'(ack), 32'd0);
    do_stop();
    chk("extra_sb_drained", 32'(sbq.size()), 32'd0);
    model_apply(K_WR, 7'h05, 9'h05A);
    readback("extra");

    // STOP after 4 bits of BYTE2: abort, no write; then a normal packet.
    expect_evt(K_ABORT, 7'h00, 9'h000);
    do_start();
    send_byte(8'h34); get_ack(ack);
    send_byte(8'h08); get_ack(ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    do_stop();
    chk("abort_sb_drained", 32'(sbq.size()), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    readback("abort");
    vt[0] = '{8'h34, 8'h08, 8'h55, 3'b111, K_WR, 7'h04, 9'h055};
    run_vec(8, vt[0]);

    // Repeated START before BYTE2 completes, then the retried packet.
    expect_evt(K_ABORT, 7'h00, 9'h000);
    expect_evt(K_WR, 7'h06, 9'h077);
    do_start();
    send_byte(8'h34); get_ack(ack);
    send_byte(8'h0C); get_ack(ack);
    do_start();
    chk("rstart_busy", 32'(busy), 32'd1);
    send_byte(8'h34); get_ack(ack);
    chk("rstart_ack_addr", 32'(ack), 32'd1);
    send_byte(8'h0C); get_ack(ack);
    send_byte(8'h77); get_ack(ack);
    chk("rstart_ack_b2", 32'(ack), 32'd1);
    do_stop();
    chk("rstart_sb_drained", 32'(sbq.size()), 32'd0);
    model_apply(K_WR, 7'h06, 9'h077);
    readback("rstart");

`ifdef I2C_GLITCH_FILTER_EN
    // Short SCL glitch during BYTE1 must not be taken as a clock.
    expect_evt(K_WR, 7'h08, 9'h033);
    do_start();
    send_byte(8'h34); get_ack(ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) send_bit_glitch(1'b0);
      else send_bit((i == 4) ? 1'b1 : 1'b0);
    end
    get_ack(ack);
    chk("glitch_ack_b1", 32'(ack), 32'd1);
    send_byte(8'h33); get_ack(ack);
    chk("glitch_ack_b2", 32'(ack), 32'd1);
    do_stop();
    chk("glitch_sb_drained", 32'(sbq.size()), 32'd0);
    model_apply(K_WR, 7'h08, 9'h033);
    readback("glitch");
`endif

    // Reset while the DUT is driving ACK0.
    do_start();
    send_byte(8'h34);
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(2);
    chk("mid_ack0_driven", 32'(sdat), 32'd0);
    reset = 1'b1;
    wait_clk(1);
    chk("mid_rst_sdat_released", 32'(sdat), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(10);
    chk("post_mid_rst_busy", 32'(busy), 32'd0);
    model_defaults();
    readback("mid_rst");
    chk("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
